// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: receives a framed big-endian program image one byte at a time,
// writes each assembled 32-bit word into instruction RAM from address 0, stalls the CPU
// while loading and reports done (good checksum) or error (bad count or checksum).
module instruction_ram_loader #(
    parameter int unsigned MAX_WORDS = 83
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        wrEnable,
    output logic [9:0]  wrAddress,
    output logic [31:0] wrData,
    output logic        cpuHold,
    output logic        loadDone,
    output logic        loadError
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_hi_q, count_hi_d;
    logic [9:0]  count_q, count_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;        // first three bytes of the word being assembled
    logic [9:0]  word_idx_q, word_idx_d;
    logic [9:0]  wr_address_q, wr_address_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;

    logic        transfer;
    logic [9:0]  hdr_count;
    logic        hdr_bad;

    assign transfer  = byteValid & byteReady;
    assign hdr_count = {count_hi_q[1:0], byteIn};
    assign hdr_bad   = (count_hi_q[7:2] != 6'd0) || (hdr_count == 10'd0) ||
                       (32'(hdr_count) > MAX_WORDS);

    assign wrAddress = wr_address_q;
    assign wrData    = wr_data_q;
    assign cpuHold   = cpu_hold_q;
    assign loadDone  = load_done_q;
    assign loadError = load_error_q;

    // Next-state logic, byte handshake and write strobe
    always_comb begin
        state_d      = state_q;
        count_hi_d   = count_hi_q;
        count_d      = count_q;
        checksum_d   = checksum_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_idx_d   = word_idx_q;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        byteReady    = 1'b0;
        wrEnable     = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d      = StHdrHi;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    checksum_d   = 8'd0;
                    word_idx_d   = 10'd0;
                    byte_idx_d   = 2'd0;
                end
            end
            StHdrHi: begin
                byteReady = 1'b1;
                if (transfer) begin
                    count_hi_d = byteIn;
                    state_d    = StHdrLo;
                end
            end
            StHdrLo: begin
                byteReady = 1'b1;
                if (transfer) begin
                    if (hdr_bad) begin
                        state_d      = StError;
                        load_error_d = 1'b1;
                    end else begin
                        count_d = hdr_count;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                byteReady = 1'b1;
                if (transfer) begin
                    checksum_d = checksum_q + byteIn;
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = {word_q[15:0], byteIn};
                    if (byte_idx_q == 2'd3) begin
                        wr_data_d    = {word_q, byteIn};
                        wr_address_d = word_idx_q;
                        state_d      = StWrite;
                    end
                end
            end
            StWrite: begin
                wrEnable   = 1'b1;
                word_idx_d = word_idx_q + 10'd1;
                state_d    = (word_idx_q + 10'd1 == count_q) ? StCheck : StData;
            end
            StCheck: begin
                byteReady = 1'b1;
                if (transfer) begin
                    if (byteIn == checksum_q) begin
                        state_d     = StDone;
                        load_done_d = 1'b1;
                    end else begin
                        state_d      = StError;
                        load_error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Hold tracks the state being entered so it rises with the first header state
        cpu_hold_d = !(state_d inside {StIdle, StDone, StError});
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StIdle;
            count_hi_q   <= 8'd0;
            count_q      <= 10'd0;
            checksum_q   <= 8'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 24'd0;
            word_idx_q   <= 10'd0;
            wr_address_q <= 10'd0;
            wr_data_q    <= 32'd0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_hi_q   <= count_hi_d;
            count_q      <= count_d;
            checksum_q   <= checksum_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_idx_q   <= word_idx_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Self-checking bench for instruction_ram_loader: frame-level reference model feeds a write
// scoreboard; a monitor pops and compares every RAM write strobe.
module tb_instruction_ram_loader;

    localparam int unsigned MAX_WORDS = 83;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byteIn = 8'd0;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic        wrEnable;
    logic [9:0]  wrAddress;
    logic [31:0] wrData;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;

    instruction_ram_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .start     (start),
        .byteIn    (byteIn),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .wrEnable  (wrEnable),
        .wrAddress (wrAddress),
        .wrData    (wrData),
        .cpuHold   (cpuHold),
        .loadDone  (loadDone),
        .loadError (loadError)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_edge = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest predicted write
    always @(negedge clock) begin
        if (wrEnable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         wrAddress, wrData);
            end else begin
                mon_e = exp_q.pop_front();
                if (wrAddress !== mon_e.addr || wrData !== mon_e.data) begin
                    errors++;
                    $display("FAIL write: got (0x%0h,0x%0h) expected (0x%0h,0x%0h)",
                             wrAddress, wrData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Reference model: res 1 = done, 2 = error; pushes every write the frame should cause
    task automatic predict(output int res, output bit hdr_bad);
        int cnt;
        int sum;
        logic [7:0] hi;
        logic [31:0] w;
        hi  = frame[0];
        cnt = int'(hi[1:0]) * 256 + int'(frame[1]);
        hdr_bad = (hi[7:2] != 0) || (cnt == 0) || (cnt > int'(MAX_WORDS));
        if (hdr_bad) begin
            res = 2;
            return;
        end
        sum = 0;
        for (int i = 0; i < cnt; i++) begin
            w = {frame[2 + 4 * i], frame[3 + 4 * i], frame[4 + 4 * i], frame[5 + 4 * i]};
            exp_q.push_back('{addr: 10'(i), data: w});
            for (int b = 0; b < 4; b++) sum += int'(frame[2 + 4 * i + b]);
        end
        res = ((sum % 256) == int'(frame[2 + 4 * cnt])) ? 1 : 2;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        int sum;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n / 256));
        frame.push_back(8'(n % 256));
        sum = 0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame.push_back(b);
            sum += int'(b);
        end
        if (corrupt) frame.push_back(8'((sum + 1 + int'($urandom_range(0, 254))) % 256));
        else frame.push_back(8'(sum % 256));
    endtask

    task automatic set_frame(input logic [87:0] bytes, input int n);
        frame.delete();
        for (int i = n - 1; i >= 0; i--) frame.push_back(bytes[8 * i +: 8]);
    endtask

    // Offer the first nbytes of frame; start_at >= 0 pulses start on that iteration
    task automatic send(input int nbytes, input bit gaps, input int start_at);
        int idx;
        int iter;
        bit tog;
        bit v;
        bit rdy;
        idx = 0;
        iter = 0;
        tog = 1'b0;
        while (idx < nbytes) begin
            @(negedge clock);
            tog = ~tog;
            v = gaps ? (tog && ($urandom_range(0, 3) != 0)) : 1'b1;
            byteIn = frame[idx];
            byteValid = v;
            start = (iter == start_at);
            rdy = byteReady;
            @(posedge clock);
            #1;
            if (v && rdy) begin
                if (idx == 0) first_edge = cyc;
                idx++;
            end
            iter++;
            if (iter > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", idx, nbytes);
                break;
            end
        end
        @(negedge clock);
        byteValid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_result(input int exp_res, input string tag, output int lat);
        int n;
        n = 0;
        while (loadDone !== 1'b1 && loadError !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done/error after frame", tag);
        end
        lat = cyc - first_edge + 1;
        check({tag, "_done"}, loadDone, (exp_res == 1));
        check({tag, "_error"}, loadError, (exp_res == 2));
        check({tag, "_hold"}, cpuHold, 1'b0);
        check({tag, "_ready"}, byteReady, 1'b0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_hold_rise"}, cpuHold, 1'b1);
        check({tag, "_flags_clear"}, {loadDone, loadError}, 2'b00);
    endtask

    task automatic run_frame(input string tag, input bit gaps, output int lat);
        int res;
        bit bad;
        do_start(tag);
        predict(res, bad);
        send(bad ? 2 : frame.size(), gaps, -1);
        wait_result(res, tag, lat);
    endtask

    initial begin
        int lat;
        int res;
        bit bad;
        logic [7:0] hdr;

        // Reset state, with bytes offered while idle
        byteValid = 1'b1;
        byteIn = 8'hA5;
        repeat (3) @(negedge clock);
        check("rst_ready", byteReady, 1'b0);
        check("rst_wren", wrEnable, 1'b0);
        check("rst_hold", cpuHold, 1'b0);
        check("rst_flags", {loadDone, loadError}, 2'b00);
        check("rst_addr", wrAddress, 10'd0);
        check("rst_data", wrData, 32'd0);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_ready", byteReady, 1'b0);
        check("idle_hold", cpuHold, 1'b0);
        byteValid = 1'b0;

        // Two-word load with exact latency
        set_frame(88'h00_02_6C_00_00_00_68_00_00_00_D4, 11);
        run_frame("load2", 1'b0, lat);
        check("load2_latency", lat, 13);
        check("load2_addr_held", wrAddress, 10'd1);
        check("load2_data_held", wrData, 32'h6800_0000);

        // Bad counts: zero, one past the maximum, nonzero reserved bits
        set_frame(88'h0000, 2);
        run_frame("cnt_zero", 1'b0, lat);
        check("cnt_zero_latency", lat, 2);
        set_frame(88'h0054, 2);
        run_frame("cnt_84", 1'b0, lat);
        check("cnt_84_latency", lat, 2);
        set_frame(88'h0401, 2);
        run_frame("cnt_rsvd", 1'b0, lat);

        // Checksum mismatch: the word is still written
        set_frame(88'h00_01_70_00_00_00_71, 7);
        run_frame("bad_sum", 1'b0, lat);

        // Gapped stream
        set_frame(88'h00_02_6C_00_00_00_68_00_00_00_D4, 11);
        run_frame("gaps", 1'b1, lat);

        // Reset after six data bytes: only word 0 goes out
        do_start("rstmid");
        exp_q.push_back('{addr: 10'd0, data: 32'h6C00_0000});
        send(8, 1'b0, -1);
        #2;
        resetN = 1'b0;
        #1;
        check("rstmid_ready", byteReady, 1'b0);
        check("rstmid_wren", wrEnable, 1'b0);
        check("rstmid_hold", cpuHold, 1'b0);
        check("rstmid_flags", {loadDone, loadError}, 2'b00);
        check("rstmid_addr", wrAddress, 10'd0);
        check("rstmid_data", wrData, 32'd0);
        check("rstmid_pending", exp_q.size(), 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        run_frame("after_rst", 1'b0, lat);

        // Start pulse while busy is ignored; start in DONE re-arms (checked in do_start)
        do_start("busy_start");
        predict(res, bad);
        send(frame.size(), 1'b0, 7);
        wait_result(res, "busy_start", lat);
        check("busy_start_latency", lat, 13);
        build_frame(3, 1'b0);
        run_frame("rearm", 1'b0, lat);

        // Largest legal image, back to back
        build_frame(int'(MAX_WORDS), 1'b0);
        run_frame("max", 1'b0, lat);
        check("max_latency", lat, 2 + 5 * int'(MAX_WORDS) + 1);

        // Randomized frames: sizes, gaps, corruption and bad headers
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                frame.delete();
                hdr = 8'($urandom_range(0, 255));
                if (hdr[7:2] == 6'd0 && $urandom_range(0, 1) == 1) hdr = 8'h00;
                frame.push_back(hdr);
                frame.push_back(hdr == 8'h00 ? 8'($urandom_range(84, 255)) :
                                               8'($urandom_range(0, 255)));
            end else begin
                build_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0));
            end
            run_frame("rand", $urandom_range(0, 1) == 1, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_ram_loader.md
# instruction_ram_loader

Byte-stream program loader: the write-side counterpart of the instruction RAM read port. Receives a framed program image one byte at a time (from the host/serial front end), assembles big-endian 32-bit instruction words, and issues one write per word into instruction memory starting at address 0. It holds the processor in stall while loading and reports completion or framing/checksum error.

## Interface
- MAX_WORDS, 83, instruction memory depth in words; legal word count is 1..MAX_WORDS (≤ 1024)
- clock  in  1  system clock, all state on posedge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; arms a load when idle, done or error
- byteIn  in  8  incoming stream byte
- byteValid  in  1  byteIn valid this cycle
- byteReady  out  1  loader accepts a byte this cycle; transfer = byteValid & byteReady
- wrEnable  out  1  one-cycle write strobe to instruction RAM
- wrAddress  out  10  word address of the write
- wrData  out  32  instruction word to write
- cpuHold  out  1  stall request to the processor, high while busy
- loadDone  out  1  sticky: last load completed with good checksum
- loadError  out  1  sticky: last load aborted (bad count or checksum)

## Operation
- Frame: COUNT_HI, COUNT_LO, then count×4 data bytes (MSB first), then 1 checksum byte.
- Count = {COUNT_HI[1:0], COUNT_LO}; COUNT_HI[7:2] ≠ 0, count = 0 or count > MAX_WORDS → ERROR.
- Checksum = 8-bit modulo-256 sum of data bytes only (not count bytes); must equal checksum byte.
- States: IDLE → (start) HDR_HI → HDR_LO → DATA → WRITE → (more words) DATA / (last) CHECK → DONE or ERROR.
- IDLE: byteReady=0, cpuHold=0. start clears loadDone/loadError, clears checksum, wrAddress target=0, goes HDR_HI.
- HDR_HI/HDR_LO/DATA/CHECK: byteReady=1; advance only on transfer.
- DATA: 2-bit byte index; byte 0→[31:24] … byte 3→[7:0]; after 4th byte go WRITE.
- WRITE: byteReady=0, wrEnable=1 for exactly one cycle with wrAddress=current word index, wrData=assembled word; index increments after.
- CHECK: on transfer compare; match → DONE (loadDone=1), else ERROR (loadError=1).
- DONE/ERROR: byteReady=0, cpuHold=0, flags held until next start or reset.
- start while in HDR_HI..CHECK or WRITE: ignored.
- Bytes presented while byteReady=0: not consumed, no effect.
- Words already written before an ERROR remain in RAM; no rollback.

## Timing
- Reset (resetN=0, asynchronous): state IDLE; byteReady, wrEnable, cpuHold, loadDone, loadError = 0; wrAddress = 0; wrData = 0; checksum, index, count = 0.
- Reset mid-load: immediate abort to IDLE, no further writes, no flag set.
- cpuHold is registered: high from the cycle after start is sampled until the cycle after entering DONE/ERROR.
- Byte accept latency: state updates the cycle after the transfer edge.
- Per word: minimum 5 cycles (4 transfers + 1 WRITE); wrEnable asserted the cycle after 4th byte transfer.
- Full load with back-to-back bytes: 2 + 5·count + 1 cycles from first header transfer to DONE/ERROR.
- Header error detected on the cycle after COUNT_LO transfer; no write ever issued.
- wrAddress/wrData stable during wrEnable and held afterwards until next write.

## Test plan
- Load 2 words: start, bytes 00 02 6C 00 00 00 68 00 00 00 D4 → writes (0,0x6C000000),(1,0x68000000); loadDone=1, cpuHold falls; total 13 cycles after first header byte.
- Bad count: bytes 00 00 → loadError=1, no wrEnable; repeat with 00 54 (84 > 83) and 04 01 → loadError=1 each.
- Checksum mismatch: 1-word frame 00 01 70 00 00 00 71 → write (0,0x70000000) happens, then loadError=1, loadDone=0.
- Backpressure/gaps: same 2-word frame with byteValid toggled every other cycle and held during WRITE → identical writes; no byte lost or duplicated.
- Reset mid-load: assert resetN=0 after 6 data bytes → all outputs 0 immediately; subsequent start + clean frame loads correctly from address 0.
- Start while busy: pulse start during DATA → ignored, load completes normally; start in DONE clears loadDone and re-arms.
